precomp_divider: RTL and testbench

- Sequential radix-16 divider that undoes the precomputation multiplier: divides a (4*n+1)-bit filter output sample by an n-bit coefficient.
- Builds a table of the 16 divisor multiples (0·d … 15·d) once per operation with shift/add/subtract.
- Then resolves one 4-bit quotient digit per cycle, MSB first, by table comparison.
- Sits downstream of the FIR output register for gain normalisation and coefficient self-check.

---
 rtl/precomp_divider.sv | 213 +++++++++++++++++++++
 tb/tb_precomp_divider.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/precomp_divider.sv
// precomp_divider: sequential radix-16 divider that undoes the precomputation
// multiplier. A (4n+1)-bit dividend is divided by an n-bit divisor by first
// building a table of the 16 divisor multiples, then resolving one 4-bit
// quotient digit per cycle, most significant digit first.
// Optional feature macro: PRECOMP_CACHE_EN keeps the last non-zero divisor and
// its multiple table so a repeated divisor skips the table-build cycle.
module precomp_divider #(
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*n:0]   dividend,
  input  logic [n-1:0]   divisor,
  output logic           out_valid,
  output logic [4*n:0]   quotient,
  output logic [n-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int D  = n + 1;
  localparam int W  = 4 * n + 1;
  localparam int PW = 4 * D;
  localparam int MW = n + 4;
  localparam int CW = $clog2(D + 1);

  typedef enum logic [1:0] {IDLE, PRECOMP, DIVIDE, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    dividend_q, dividend_d;
  logic [n-1:0]    divisor_q, divisor_d;
  logic [PW-1:0]   work_q, work_d;
  logic [n-1:0]    r_q, r_d;
  logic [W-1:0]    quot_q, quot_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]   m_q [16];
  logic [MW-1:0]   m_d [16];
  logic [W-1:0]    quotient_q, quotient_d;
  logic [n-1:0]    remainder_q, remainder_d;
  logic            dz_q, dz_d;

  logic [MW-1:0]   tbl [16];
  logic [MW-1:0]   t;
  logic [3:0]      qd;
  logic [n-1:0]    rem_next;
  logic [W-1:0]    quot_next;

`ifdef PRECOMP_CACHE_EN
  logic            cvalid_q, cvalid_d;
  logic [n-1:0]    cdiv_q, cdiv_d;
`endif

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;

  // Multiple table k*d built from shifts and single adds/subtracts only.
  always_comb begin
    logic [MW-1:0] e, m3, m5, m7, m8;
    e  = {4'b0000, divisor_q};
    m3 = (e << 1) + e;
    m5 = (e << 2) + e;
    m7 = (e << 3) - e;
    m8 = e << 3;
    tbl[0]  = '0;
    tbl[1]  = e;
    tbl[2]  = e << 1;
    tbl[3]  = m3;
    tbl[4]  = e << 2;
    tbl[5]  = m5;
    tbl[6]  = m3 << 1;
    tbl[7]  = m7;
    tbl[8]  = m8;
    tbl[9]  = m8 + e;
    tbl[10] = m5 << 1;
    tbl[11] = m8 + m3;
    tbl[12] = m3 << 2;
    tbl[13] = m8 + m5;
    tbl[14] = m7 << 1;
    tbl[15] = (e << 4) - e;
  end

  // Digit selection: largest multiple not exceeding the shifted partial remainder.
  always_comb begin
    t  = {r_q, work_q[PW-1 -: 4]};
    qd = '0;
    for (int k = 1; k < 16; k++) begin
      if (m_q[k] <= t) qd = 4'(k);
    end
    rem_next  = n'(t - m_q[qd]);
    quot_next = W'({quot_q, qd});
  end

  // Next-state and datapath updates; DIVIDE cycle 0 loads the working
  // registers so cached and freshly built tables enter the digit loop alike.
  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    work_d      = work_q;
    r_d         = r_q;
    quot_d      = quot_q;
    cnt_d       = cnt_q;
    m_d         = m_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
`ifdef PRECOMP_CACHE_EN
    cvalid_d    = cvalid_q;
    cdiv_d      = cdiv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dividend_d = dividend;
          divisor_d  = divisor;
          cnt_d      = '0;
          r_d        = '0;
`ifdef PRECOMP_CACHE_EN
          if (cvalid_q && (divisor == cdiv_q)) state_d = DIVIDE;
          else                                 state_d = PRECOMP;
`else
          state_d = PRECOMP;
`endif
        end
      end
      PRECOMP: begin
        m_d = tbl;
`ifdef PRECOMP_CACHE_EN
        cdiv_d   = divisor_q;
        cvalid_d = (divisor_q != '0);
`endif
        if (divisor_q == '0) begin
          quotient_d  = '1;
          remainder_d = dividend_q[n-1:0];
          dz_d        = 1'b1;
          state_d     = DONE;
        end else begin
          r_d     = '0;
          cnt_d   = '0;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (cnt_q == '0) begin
          work_d = PW'(dividend_q);
          r_d    = '0;
          quot_d = '0;
          cnt_d  = CW'(1);
        end else begin
          work_d = {work_q[PW-5:0], 4'b0000};
          r_d    = rem_next;
          quot_d = quot_next;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == CW'(D)) begin
            quotient_d  = quot_next;
            remainder_d = rem_next;
            dz_d        = 1'b0;
            state_d     = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      work_q      <= '0;
      r_q         <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      m_q         <= '{default: '0};
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      work_q      <= work_d;
      r_q         <= r_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      m_q         <= m_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
    end
  end

`ifdef PRECOMP_CACHE_EN
  // Divisor cache tag and valid flag; reset forgets the cached table.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cvalid_q <= 1'b0;
      cdiv_q   <= '0;
    end else begin
      cvalid_q <= cvalid_d;
      cdiv_q   <= cdiv_d;
    end
  end
`endif

endmodule

// File: tb/tb_precomp_divider.sv
// tb_precomp_divider: scoreboard bench for precomp_divider (n=4). Stimulus
// pushes hand-computed results; a negedge monitor pops on out_valid.
// Latency is the index of the posedge, counted from the accept edge, at
// which out_valid is first sampled high.
module tb_precomp_divider;

  localparam int n = 4;
  localparam int W = 4 * n + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [n-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [n-1:0] divisor = '0;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [n-1:0] remainder;
  logic         div_by_zero;

  exp_t expQ[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   cycleCnt = 0;
  int   acceptEdge = 0;
  bit   busy = 1'b0;
  bit   cacheValidTB = 1'b0;
  int   cacheDivTB = 0;

  precomp_divider #(.n(n)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected latency including the divisor cache when it is built in.
  function automatic int latFor(input int dvs);
    int lat;
    if (dvs == 0) begin
      cacheValidTB = 1'b0;
      return 2;
    end
    lat = 8;
`ifdef PRECOMP_CACHE_EN
    if (cacheValidTB && dvs == cacheDivTB) lat = 7;
`endif
    cacheValidTB = 1'b1;
    cacheDivTB   = dvs;
    return lat;
  endfunction

  task automatic pushExp(input int q, input int r, input bit dz, input int dvs);
    exp_t e;
    e.q   = W'(q);
    e.r   = n'(r);
    e.dz  = dz;
    e.lat = latFor(dvs);
    expQ.push_back(e);
  endtask

  task automatic waitDrained(input string name);
    int k = 0;
    while (expQ.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s: timeout, %0d results outstanding, expected 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic applyStimulus(input int dvd, input int dvs, input int q, input int r, input bit dz, input string name);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    dividend = W'(dvd);
    divisor  = n'(dvs);
    pushExp(q, r, dz, dvs);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitDrained(name);
  endtask

  // Monitor: busy-window in_ready check, result scoreboard, accept tracking.
  always @(negedge clk) begin
    if (!reset) begin
      busy = 1'b0;
    end else begin
      if (busy) checkOutput("in_ready_busy", 32'(in_ready), 32'd0);
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("quotient", 32'(quotient), 32'(e.q));
          checkOutput("remainder", 32'(remainder), 32'(e.r));
          checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dz));
          checkOutput("latency", 32'(cycleCnt + 1 - acceptEdge), 32'(e.lat));
        end
        busy = 1'b0;
      end
      if (in_valid && in_ready) begin
        acceptEdge = cycleCnt + 1;
        busy = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hDvd [11] = '{1000, 3, 77, 4000, 6, 9, 12, 13, 500, 99999, 42};
    int hDvs [11] = '{13, 1, 2, 3, 4, 5, 6, 7, 8, 11, 9};

    // Reset state while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_quotient", 32'(quotient), 32'd0);
    checkOutput("reset_remainder", 32'(remainder), 32'd0);
    checkOutput("reset_dz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Directed divisions.
    applyStimulus(100, 7, 14, 2, 1'b0, "div_100_7");
    applyStimulus(131071, 15, 8738, 1, 1'b0, "div_max_15");
    applyStimulus(5, 9, 0, 5, 1'b0, "div_5_9");
    applyStimulus(1234, 0, 131071, 2, 1'b1, "div_by_zero");
    applyStimulus(100, 7, 14, 2, 1'b0, "dz_clear");
    applyStimulus(200, 7, 28, 4, 1'b0, "div_200_7");
    applyStimulus(200, 3, 66, 2, 1'b0, "div_200_3");

    // in_valid held high with operands changing every cycle: only vectors
    // 0 and 9 land while in_ready is high.
    pushExp(76, 12, 1'b0, hDvs[0]);
    pushExp(9090, 9, 1'b0, hDvs[9]);
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      dividend = W'(hDvd[i]);
      divisor  = n'(hDvs[i]);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitDrained("hold_valid");
    repeat (12) @(posedge clk);

    // Reset sampled at T+4 of an operation aborts it.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    dividend = W'(100);
    divisor  = n'(7);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cacheValidTB = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_quotient", 32'(quotient), 32'd0);
    checkOutput("abort_remainder", 32'(remainder), 32'd0);
    checkOutput("abort_dz", 32'(div_by_zero), 32'd0);
    repeat (12) @(posedge clk);
    applyStimulus(100, 7, 14, 2, 1'b0, "after_abort");
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
